kbd_scancode_tracker: RTL and testbench

- Upstream stage of the 2048 game top. Consumes decoded PS/2 Set-2 scan-code bytes from the PS/2 receiver.
- Maintains a live 26-bit pressed/released map for letters A–Z (bit 0 = A … bit 25 = Z). This map drives the key_status input of the game top and its screen modules.
- Also emits a one-cycle press strobe with the key index, for consumers that need edge events.

---
 rtl/kbd_pkg.sv | 26 ++
 rtl/kbd_letter_lut.sv | 42 ++++
 rtl/kbd_scancode_tracker.sv | 121 ++++++++++++
 tb/tb_kbd_scancode_tracker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and FSM encoding for the PS/2 Set-2 scan-code tracker.
package kbd_pkg;

  localparam int KEY_COUNT = 26;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERR1  = 8'hFF;
  localparam logic [7:0] SC_FAIL  = 8'hFC;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } kbd_state_t;

  // Keyboard self-test / error bytes that invalidate everything we know.
  function automatic logic is_reset_code(input logic [7:0] code);
    return (code == SC_BAT) || (code == SC_ERR0) ||
           (code == SC_ERR1) || (code == SC_FAIL);
  endfunction

endpackage

// File: rtl/kbd_letter_lut.sv
// Combinational Set-2 make-code to letter index (A=0 .. Z=25) lookup.
module kbd_letter_lut (
  input  logic [7:0] scan_code,
  output logic       is_letter,
  output logic [4:0] letter_idx
);

  always_comb begin
    is_letter  = 1'b1;
    letter_idx = 5'd0;
    case (scan_code)
      8'h1C: letter_idx = 5'd0;
      8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;
      8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;
      8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;
      8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;
      8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;
      8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;
      8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;
      8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;
      8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;
      8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;
      8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;
      8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;
      8'h1A: letter_idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
  end

endmodule

// File: rtl/kbd_scancode_tracker.sv
// Tracks the held state of letter keys A-Z from PS/2 Set-2 bytes and strobes new presses.
// Define KBD_RELEASE_TIMEOUT_EN to force-release all keys after TIMEOUT_CYCLES idle cycles.
module kbd_scancode_tracker
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int TO_WIDTH       = 27
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // scan_valid is a single-cycle strobe with no back-pressure: the byte on
  // scan_code is consumed on every rising edge where scan_valid = 1.
  input  logic                 scan_valid,
  input  logic [7:0]           scan_code,
  output logic [KEY_COUNT-1:0] key_status,
  output logic                 key_down_strobe,
  output logic [4:0]           key_down_idx
);

  if ((64'd1 << TO_WIDTH) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_check
    $error("TO_WIDTH too narrow for TIMEOUT_CYCLES");
  end

  kbd_state_t           state, state_n;
  logic [KEY_COUNT-1:0] status_n;
  logic                 strobe_n;
  logic [4:0]           idx_n;
  logic                 is_letter;
  logic [4:0]           letter_idx;
  logic                 timeout_fire;

  kbd_letter_lut u_lut (
    .scan_code  (scan_code),
    .is_letter  (is_letter),
    .letter_idx (letter_idx)
  );

`ifdef KBD_RELEASE_TIMEOUT_EN
  logic [TO_WIDTH-1:0] idle_cnt;

  // Fires only on the step into TIMEOUT_CYCLES, so once per idle period.
  assign timeout_fire = !scan_valid && (idle_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (scan_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_WIDTH'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      key_status      <= '0;
      key_down_strobe <= 1'b0;
      key_down_idx    <= 5'd0;
    end else begin
      state           <= state_n;
      key_status      <= status_n;
      key_down_strobe <= strobe_n;
      key_down_idx    <= idx_n;
    end
  end

  always_comb begin
    state_n  = state;
    status_n = key_status;
    strobe_n = 1'b0;
    idx_n    = key_down_idx;
    if (scan_valid) begin
      if (is_reset_code(scan_code)) begin
        state_n  = ST_IDLE;
        status_n = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (scan_code == SC_BREAK) begin
              state_n = ST_BREAK;
            end else if (scan_code == SC_EXT) begin
              state_n = ST_EXT;
            end else if (is_letter) begin
              status_n[letter_idx] = 1'b1;
              if (!key_status[letter_idx]) begin
                strobe_n = 1'b1;
                idx_n    = letter_idx;
              end
            end
          end
          ST_BREAK: begin
            if (is_letter) begin
              status_n[letter_idx] = 1'b0;
              state_n              = ST_IDLE;
            end else if (scan_code == SC_BREAK) begin
              state_n = ST_BREAK;
            end else if (scan_code == SC_EXT) begin
              state_n = ST_EXT_BREAK;
            end else begin
              state_n = ST_IDLE;
            end
          end
          ST_EXT: begin
            state_n = (scan_code == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
          end
          default: begin
            state_n = ST_IDLE;
          end
        endcase
      end
    end else if (timeout_fire) begin
      state_n  = ST_IDLE;
      status_n = '0;
    end
  end

endmodule

// File: tb/tb_kbd_scancode_tracker.sv
// Self-checking bench for kbd_scancode_tracker: vector table, corner sequences, random vs. model.
// Define KBD_RELEASE_TIMEOUT_EN to also exercise the idle force-release with a 50-cycle timeout.
module tb_kbd_scancode_tracker;

`ifdef KBD_RELEASE_TIMEOUT_EN
  localparam int TB_TO = 50;
`else
  localparam int TB_TO = 100_000_000;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scan_valid = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic [25:0] key_status;
  logic        key_down_strobe;
  logic [4:0]  key_down_idx;

  int n_checks = 0;
  int n_errors = 0;

  kbd_scancode_tracker #(
    .TIMEOUT_CYCLES (TB_TO),
    .TO_WIDTH       (27)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .scan_valid      (scan_valid),
    .scan_code       (scan_code),
    .key_status      (key_status),
    .key_down_strobe (key_down_strobe),
    .key_down_idx    (key_down_idx)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] letter_codes [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  logic [25:0] m_status;
  logic        m_strobe;
  logic [4:0]  m_idx;
  bit          m_seen_e0, m_seen_f0;
  int          m_idle;

  function automatic int letter_of(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (letter_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic void model_step(input logic rst_n, input logic v, input logic [7:0] b);
    int li;
    m_strobe = 1'b0;
    if (!rst_n) begin
      m_status = '0; m_idx = '0; m_seen_e0 = 0; m_seen_f0 = 0; m_idle = 0;
      return;
    end
    if (!v) begin
`ifdef KBD_RELEASE_TIMEOUT_EN
      if (m_idle < TB_TO) begin
        m_idle++;
        if (m_idle == TB_TO) begin
          m_status = '0; m_seen_e0 = 0; m_seen_f0 = 0;
        end
      end
`endif
      return;
    end
    m_idle = 0;
    li = letter_of(b);
    if (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF) begin
      m_status = '0; m_seen_e0 = 0; m_seen_f0 = 0;
    end else if (m_seen_e0 && m_seen_f0) begin
      m_seen_e0 = 0; m_seen_f0 = 0;
    end else if (m_seen_e0) begin
      if (b == 8'hF0) m_seen_f0 = 1; else m_seen_e0 = 0;
    end else if (m_seen_f0) begin
      if (b == 8'hE0) m_seen_e0 = 1;
      else if (b != 8'hF0) begin
        if (li >= 0) m_status[li] = 1'b0;
        m_seen_f0 = 0;
      end
    end else begin
      if (b == 8'hF0) m_seen_f0 = 1;
      else if (b == 8'hE0) m_seen_e0 = 1;
      else if (li >= 0 && !m_status[li]) begin
        m_status[li] = 1'b1;
        m_strobe = 1'b1;
        m_idx = 5'(li);
      end
    end
  endfunction

  // ---------------- driver / checker ----------------
  task automatic apply(input logic v, input logic [7:0] c);
    scan_valid = v;
    scan_code  = c;
    @(posedge clk);
    #1;
    model_step(reset_n, v, c);
  endtask

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [25:0] st, input logic sb,
                           input logic [4:0] ix);
    check({tag, ".status"}, key_status, st);
    check({tag, ".strobe"}, 26'(key_down_strobe), 26'(sb));
    check({tag, ".idx"}, 26'(key_down_idx), 26'(ix));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    apply(1'b0, 8'h00);
    apply(1'b0, 8'h00);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  c;
    logic [25:0] st;
    logic        sb;
    logic [4:0]  ix;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [7:0] err_codes [4];
    err_codes = '{8'hAA, 8'hFC, 8'h00, 8'hFF};

    tbl.push_back('{1'b1, 8'h1C, 26'h0000001, 1'b1, 5'd0});
    tbl.push_back('{1'b0, 8'h00, 26'h0000001, 1'b0, 5'd0});
    tbl.push_back('{1'b1, 8'h1C, 26'h0000001, 1'b0, 5'd0});
    tbl.push_back('{1'b1, 8'h1C, 26'h0000001, 1'b0, 5'd0});
    tbl.push_back('{1'b1, 8'hF0, 26'h0000001, 1'b0, 5'd0});
    tbl.push_back('{1'b1, 8'h1C, 26'h0000000, 1'b0, 5'd0});
    tbl.push_back('{1'b1, 8'h1A, 26'h2000000, 1'b1, 5'd25});
    tbl.push_back('{1'b0, 8'h00, 26'h2000000, 1'b0, 5'd25});
    tbl.push_back('{1'b0, 8'h00, 26'h2000000, 1'b0, 5'd25});
    tbl.push_back('{1'b0, 8'h00, 26'h2000000, 1'b0, 5'd25});
    tbl.push_back('{1'b1, 8'h15, 26'h2010000, 1'b1, 5'd16});
    tbl.push_back('{1'b1, 8'hE0, 26'h2010000, 1'b0, 5'd16});
    tbl.push_back('{1'b1, 8'hF0, 26'h2010000, 1'b0, 5'd16});
    tbl.push_back('{1'b1, 8'h1A, 26'h2010000, 1'b0, 5'd16});
    tbl.push_back('{1'b1, 8'hE0, 26'h2010000, 1'b0, 5'd16});
    tbl.push_back('{1'b1, 8'h1C, 26'h2010000, 1'b0, 5'd16});
    tbl.push_back('{1'b1, 8'h1C, 26'h2010001, 1'b1, 5'd0});
    tbl.push_back('{1'b1, 8'h1B, 26'h2050001, 1'b1, 5'd18});
    tbl.push_back('{1'b1, 8'h23, 26'h2050009, 1'b1, 5'd3});
    tbl.push_back('{1'b1, 8'hF0, 26'h2050009, 1'b0, 5'd3});
    tbl.push_back('{1'b1, 8'hF0, 26'h2050009, 1'b0, 5'd3});
    tbl.push_back('{1'b1, 8'h1B, 26'h2010009, 1'b0, 5'd3});
    tbl.push_back('{1'b1, 8'hF0, 26'h2010009, 1'b0, 5'd3});
    tbl.push_back('{1'b1, 8'hE0, 26'h2010009, 1'b0, 5'd3});
    tbl.push_back('{1'b1, 8'h1C, 26'h2010009, 1'b0, 5'd3});
    tbl.push_back('{1'b1, 8'h1B, 26'h2050009, 1'b1, 5'd18});
    tbl.push_back('{1'b1, 8'h76, 26'h2050009, 1'b0, 5'd18});
    tbl.push_back('{1'b1, 8'hAA, 26'h0000000, 1'b0, 5'd18});
    tbl.push_back('{1'b1, 8'h23, 26'h0000008, 1'b1, 5'd3});
    tbl.push_back('{1'b1, 8'hF0, 26'h0000008, 1'b0, 5'd3});
    tbl.push_back('{1'b1, 8'hFF, 26'h0000000, 1'b0, 5'd3});
    tbl.push_back('{1'b1, 8'h23, 26'h0000008, 1'b1, 5'd3});

    do_reset();
    check_all("reset", 26'h0, 1'b0, 5'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].v, tbl[i].c);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].sb, tbl[i].ix);
    end

    // Reset in the middle of a break prefix discards it.
    apply(1'b1, 8'hF0);
    reset_n = 1'b0;
    apply(1'b0, 8'h00);
    reset_n = 1'b1;
    check_all("mid_reset", 26'h0, 1'b0, 5'd0);
    apply(1'b1, 8'h1C);
    check_all("post_reset_press", 26'h1, 1'b1, 5'd0);
    apply(1'b0, 8'h00);
    check_all("post_reset_idle", 26'h1, 1'b0, 5'd0);

`ifdef KBD_RELEASE_TIMEOUT_EN
    do_reset();
    apply(1'b1, 8'h1C);
    check_all("to_press", 26'h1, 1'b1, 5'd0);
    for (int i = 1; i < TB_TO; i++) begin
      apply(1'b0, 8'h00);
      check("to_hold", key_status, 26'h1);
    end
    apply(1'b0, 8'h00);
    check_all("to_fire", 26'h0, 1'b0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 8'h00);
      check("to_after", key_status, 26'h0);
    end
    apply(1'b1, 8'h1C);
    check_all("to_repress", 26'h1, 1'b1, 5'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic       v;
      logic [7:0] c;
      int         r;
      if ($urandom_range(0, 99) == 0) begin
        for (int k = 0; k < 55; k++) begin
          apply(1'b0, 8'h00);
          check_all("rnd_gap", m_status, m_strobe, m_idx);
        end
      end
      v = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 11);
      if (r <= 6)       c = letter_codes[$urandom_range(0, 5)];
      else if (r == 7)  c = letter_codes[$urandom_range(0, 25)];
      else if (r == 8)  c = 8'hF0;
      else if (r == 9)  c = 8'hE0;
      else if (r == 10) c = ($urandom_range(0, 3) == 0) ? err_codes[$urandom_range(0, 3)]
                                                        : 8'(($urandom_range(0, 255)));
      else              c = 8'hF0;
      apply(v, c);
      check_all("rnd", m_status, m_strobe, m_idx);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
